// File: rtl/if_fetch_pkg.sv
// Shared definitions for the instruction-fetch stage: bus widths, flag levels
// and the fetch state encoding.
package if_fetch_pkg;

    localparam logic ENABLE  = 1'b1;
    localparam logic DISABLE = 1'b0;
    localparam logic STOP    = 1'b1;
    localparam logic NO_STOP = 1'b0;

    localparam int INST_ADDR_BUS_W = 32;
    localparam int INST_BUS_W      = 32;
    localparam int STALL_BUS_W     = 6;

    localparam logic [INST_BUS_W-1:0] ZERO_WORD = '0;

    // Bit of the stall vector that holds the IF/ID pipeline register.
    localparam int STALL_IFID = 1;

    typedef enum logic {
        FETCH = 1'b0,
        VALID = 1'b1
    } fetch_state_t;

endpackage

// File: rtl/if_fetch.sv
// Instruction fetch: assembles a 32-bit word from four little-endian byte reads
// and presents it to IF/ID until accepted; EX branches abort and redirect.
//
//  state | meaning
//  FETCH | byte reads in flight (or one idle cycle after reset/branch)
//  VALID | word presented on if_flag/if_pc/if_inst, waiting for stall[1]==0
module if_fetch
    import if_fetch_pkg::*;
#(
    parameter int ADDR_W  = INST_ADDR_BUS_W,
    parameter int INST_W  = INST_BUS_W,
    parameter int STALL_W = STALL_BUS_W,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [STALL_W-1:0] stall,
    input  logic               branch_flag,
    input  logic [ADDR_W-1:0]  branch_target,
    output logic               mem_req,
    output logic [ADDR_W-1:0]  mem_addr,
    input  logic               mem_ack,
    input  logic [7:0]         mem_data,
    output logic               if_stall_req,
    output logic               if_flag,
    output logic [ADDR_W-1:0]  if_pc,
    output logic [INST_W-1:0]  if_inst
);

    fetch_state_t      state;
    logic [ADDR_W-1:0] pc;
    logic [1:0]        k;
    logic [23:0]       byte_buf;

    logic unused_stall;
    assign unused_stall = ^{stall[STALL_W-1:STALL_IFID+1], stall[0]};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= FETCH;
            pc           <= RESET_PC;
            k            <= 2'd0;
            byte_buf     <= '0;
            mem_req      <= DISABLE;
            mem_addr     <= '0;
            if_stall_req <= NO_STOP;
            if_flag      <= DISABLE;
            if_pc        <= '0;
            if_inst      <= ZERO_WORD;
        end else if (branch_flag) begin
            // Redirect wins over everything, including a same-cycle ack or accept.
            state        <= FETCH;
            pc           <= branch_target;
            k            <= 2'd0;
            mem_req      <= DISABLE;
            if_stall_req <= NO_STOP;
            if_flag      <= DISABLE;
            if_pc        <= '0;
            if_inst      <= ZERO_WORD;
        end else begin
            case (state)
                FETCH: begin
                    if (!mem_req) begin
                        mem_req      <= ENABLE;
                        mem_addr     <= pc;
                        if_stall_req <= STOP;
                    end else if (mem_ack) begin
                        if (k == 2'd3) begin
                            state        <= VALID;
                            mem_req      <= DISABLE;
                            if_stall_req <= NO_STOP;
                            if_flag      <= ENABLE;
                            if_pc        <= pc;
                            if_inst      <= {mem_data, byte_buf};
                        end else begin
                            // Shift register: after three bytes, byte 0 sits in [7:0].
                            byte_buf <= {mem_data, byte_buf[23:8]};
                            k        <= k + 2'd1;
                            mem_addr <= pc + ADDR_W'(k) + ADDR_W'(1);
                        end
                    end
                end
                VALID: begin
                    if (!stall[STALL_IFID]) begin
                        state        <= FETCH;
                        pc           <= pc + ADDR_W'(4);
                        k            <= 2'd0;
                        if_flag      <= DISABLE;
                        mem_req      <= ENABLE;
                        mem_addr     <= pc + ADDR_W'(4);
                        if_stall_req <= STOP;
                    end
                end
                default: state <= FETCH;
            endcase
        end
    end

endmodule

// File: doc/if_fetch.md
Name: if_fetch

Overview:
- Instruction-fetch stage that produces the if_flag/if_pc/if_inst triple consumed by the IF/ID pipeline register.
- Sits between the PC and the byte-wide memory controller.
- Fetches each 32-bit instruction as four little-endian byte reads and presents it for one accepted cycle.
- Handles stall holds and branch redirects from EX, and raises a stall request while a fetch is in flight.

Parameters:
ADDR_W, 32, PC/memory address width
INST_W, 32, instruction width (fixed 4 bytes)
STALL_W, 6, stall bus width; bit 1 = IF/ID hold
RESET_PC, 0, PC loaded at reset

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  reset, asynchronous, active-low (rst==0 resets)
stall  input  STALL_W  stall vector from stall controller; only stall[1] used
branch_flag  input  1  EX redirect request
branch_target  input  ADDR_W  redirect PC
mem_req  output  1  byte read request to memory controller
mem_addr  output  ADDR_W  byte address, stable while mem_req high
mem_ack  input  1  byte returned this cycle
mem_data  input  8  read byte, valid when mem_ack
if_stall_req  output  1  fetch in progress, request pipeline stall
if_flag  output  1  if_pc/if_inst valid
if_pc  output  ADDR_W  PC of presented instruction
if_inst  output  INST_W  presented instruction

Behaviour:
- Reset (rst low, async): pc=RESET_PC, state=FETCH, byte index k=0. All outputs are 0: if_flag, if_pc, if_inst, mem_req, mem_addr, if_stall_req.
- State FETCH:
  - mem_req=1 and mem_addr=pc+k, both held until mem_ack; if_stall_req=1.
  - On mem_ack, byte k is stored into buffer bits [8k+7:8k] and k increments.
  - The next byte's request is issued the following cycle; mem_req may stay high with the new address.
  - On the ack with k==3: next state VALID, if_inst=assembled word, if_pc=pc, if_flag=1, mem_req=0, if_stall_req=0.
  - mem_ack with mem_req low is ignored.
- State VALID:
  - if_flag=1; if_pc and if_inst are held stable.
  - If stall[1]==0 this cycle, the instruction is accepted. Next cycle: pc=pc+4 (mod 2^ADDR_W, wrap-around silent), k=0, if_flag=0, state=FETCH.
  - If stall[1]==1, remain in VALID with all outputs unchanged.
- Branch, with highest priority and valid in any state:
  - branch_flag=1 aborts the current fetch.
  - Next cycle: pc=branch_target, k=0, state=FETCH, if_flag=0, if_pc=0, if_inst=0.
  - mem_req drops for exactly one cycle, then re-asserts with mem_addr=branch_target.
  - A mem_ack arriving in the same cycle as branch_flag is discarded; the memory controller tolerates abandoned requests.
  - Branch and acceptance in the same cycle: branch wins, pc+4 is not taken.
- Stall during FETCH does not pause memory traffic; assembly continues and results are held in VALID.
- No alignment check: branch_target[1:0] is used as given.
- Latency: with single-cycle ack, from request of byte 0 to if_flag=1 is 4 acks + 1 cycle.
- Reset mid-fetch: partial buffer discarded, restart at RESET_PC.

Decomposition:
- Shared defines file: Enable/Disable, Stop/NoStop, ZeroWord, InstAddrBus, InstBus, StallBus, and state encodings FETCH/VALID.
- No sub-module; the byte assembler is a 24-bit shift/index register inside the block.

Test Plan:
1. Reset release, memory returns bytes 0x13,0x05,0x10,0x00 at addresses 0..3 with ack one cycle after each req -> if_flag=1, if_pc=0x0, if_inst=0x00100513, if_stall_req=0 in that cycle. Next fetch addresses are 4..7.
2. Instruction valid while stall[1]=1 for 3 cycles -> if_flag, if_pc, if_inst unchanged for 3 cycles, mem_req=0. After stall drops, mem_addr=0x4 the following cycle.
3. branch_flag=1, branch_target=0x100 while k=2 -> next cycle if_flag=0 and mem_req=0. The cycle after, mem_req=1 with mem_addr=0x100. The stale ack is ignored; assembled word comes only from 0x100..0x103.
4. branch_flag=1 in the same cycle as mem_ack for k=3 -> no if_flag pulse. Fetch restarts at branch_target.
5. pc=0xFFFFFFFC accepted -> next mem_addr=0x00000000 (wrap).
6. rst driven low mid-fetch at k=1 -> outputs 0 asynchronously. After release, fetch starts at RESET_PC with k=0.
